// File: rtl/pipeline_ctrl.sv
// Hazard/flush controller for the 5-stage core: drives PC and inter-stage
// register hold/clear, arbitrates stalls and redirects, counts stall cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal issue; redirects applied immediately when fetch is idle
// PEND  | redirect target parked in pending_pc until fetch completes
module pipeline_ctrl #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_stall_req_i,
   input  logic             mem_stall_req_i,
   input  logic             id_load_use_i,
   input  logic             ex_redirect_i,
   input  logic [XLEN-1:0]  ex_redirect_pc_i,
   input  logic             trap_i,
   input  logic [XLEN-1:0]  trap_pc_i,
   output logic             pc_hold_o,
   output logic             if_id_hold_o,
   output logic             if_id_clear_o,
   output logic             id_ex_hold_o,
   output logic             id_ex_clear_o,
   output logic             ex_mem_hold_o,
   output logic             ex_mem_clear_o,
   output logic             mem_wb_hold_o,
   output logic             mem_wb_clear_o,
   output logic             redirect_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             trap_v, exr_v, req;
   logic [XLEN-1:0]  tgt;

   logic             pc_hold_c, redirect_c;
   logic             if_id_hold_c, if_id_clear_c;
   logic             id_ex_hold_c, id_ex_clear_c;
   logic             ex_mem_hold_c, ex_mem_clear_c;
   logic             mem_wb_hold_c, mem_wb_clear_c;
   logic [XLEN-1:0]  redirect_pc_c;

   // A stalled MEM stage means the redirecting instruction is not yet final.
   assign trap_v = trap_i & ~mem_stall_req_i;
   assign exr_v  = ex_redirect_i & ~mem_stall_req_i;
   assign req    = trap_v | exr_v;
   assign tgt    = trap_v ? trap_pc_i : ex_redirect_pc_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pend_pc_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_pc_q   <= pend_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      case (state_q)
         RUN: begin
            if (!mem_stall_req_i && req && if_stall_req_i) begin
               state_d   = PEND;
               pend_pc_d = tgt;
            end
         end
         PEND: begin
            if (trap_v) begin
               pend_pc_d = trap_pc_i;
            end
            if (!if_stall_req_i) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_comb begin
      pc_hold_c      = 1'b0;
      redirect_c     = 1'b0;
      redirect_pc_c  = '0;
      if_id_hold_c   = 1'b0;
      if_id_clear_c  = 1'b0;
      id_ex_hold_c   = 1'b0;
      id_ex_clear_c  = 1'b0;
      ex_mem_hold_c  = 1'b0;
      ex_mem_clear_c = 1'b0;
      mem_wb_hold_c  = 1'b0;
      mem_wb_clear_c = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_stall_req_i) begin
               pc_hold_c      = 1'b1;
               if_id_hold_c   = 1'b1;
               id_ex_hold_c   = 1'b1;
               ex_mem_hold_c  = 1'b1;
               mem_wb_clear_c = 1'b1;
            end else if (req) begin
               if_id_clear_c = 1'b1;
               id_ex_clear_c = 1'b1;
               if (trap_v) begin
                  ex_mem_clear_c = 1'b1;
                  mem_wb_clear_c = 1'b1;
               end
               if (if_stall_req_i) begin
                  pc_hold_c = 1'b1;
               end else begin
                  redirect_c    = 1'b1;
                  redirect_pc_c = tgt;
               end
            end else if (id_load_use_i) begin
               pc_hold_c     = 1'b1;
               if_id_hold_c  = 1'b1;
               id_ex_clear_c = 1'b1;
            end else if (if_stall_req_i) begin
               pc_hold_c     = 1'b1;
               if_id_clear_c = 1'b1;
            end
         end
         PEND: begin
            // Whatever fetch delivers while pending is wrong-path.
            if_id_clear_c = 1'b1;
            if (mem_stall_req_i) begin
               id_ex_hold_c   = 1'b1;
               ex_mem_hold_c  = 1'b1;
               mem_wb_clear_c = 1'b1;
            end
            if (trap_v) begin
               id_ex_clear_c  = 1'b1;
               ex_mem_clear_c = 1'b1;
               mem_wb_clear_c = 1'b1;
            end
            if (if_stall_req_i) begin
               pc_hold_c = 1'b1;
            end else begin
               redirect_c    = 1'b1;
               redirect_pc_c = trap_v ? trap_pc_i : pend_pc_q;
            end
         end
         default: begin
            pc_hold_c = 1'b0;
         end
      endcase
   end

   // Outputs are quiet for the whole reset interval, not just after the edge.
   assign pc_hold_o      = pc_hold_c      & rst_n;
   assign redirect_o     = redirect_c     & rst_n;
   assign redirect_pc_o  = rst_n ? redirect_pc_c : '0;
   assign if_id_hold_o   = if_id_hold_c   & rst_n;
   assign if_id_clear_o  = if_id_clear_c  & rst_n;
   assign id_ex_hold_o   = id_ex_hold_c   & rst_n;
   assign id_ex_clear_o  = id_ex_clear_c  & rst_n;
   assign ex_mem_hold_o  = ex_mem_hold_c  & rst_n;
   assign ex_mem_clear_o = ex_mem_clear_c & rst_n;
   assign mem_wb_hold_o  = mem_wb_hold_c  & rst_n;
   assign mem_wb_clear_o = mem_wb_clear_c & rst_n;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_hold_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and flush controller that drives the hold/clear control inputs of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register of the 5-stage core. It arbitrates fetch stalls, memory stalls, load-use hazards, EX-stage branch/jump redirects and commit-stage trap redirects. When a redirect collides with an in-flight fetch, it holds the target in a pending register and applies it when fetch completes. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- XLEN, 64, PC width
- CNT_W, 32, stall counter width
---
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- if_stall_req_i  in  1  fetch busy; instruction not yet available
- mem_stall_req_i  in  1  data access busy in MEM
- id_load_use_i  in  1  ID instruction depends on a load currently in EX
- ex_redirect_i  in  1  EX branch mispredict or jump taken
- ex_redirect_pc_i  in  XLEN  EX target
- trap_i  in  1  exception/interrupt taken by the instruction in MEM
- trap_pc_i  in  XLEN  trap vector
- pc_hold_o  out  1  hold PC register
- if_id_hold_o, if_id_clear_o  out  1 each
- id_ex_hold_o, id_ex_clear_o  out  1 each
- ex_mem_hold_o, ex_mem_clear_o  out  1 each
- mem_wb_hold_o, mem_wb_clear_o  out  1 each
- redirect_o  out  1  load redirect_pc_o into PC this cycle
- redirect_pc_o  out  XLEN  redirect target
- stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1

## Operation
- Registers: state {RUN, PEND}, pending_pc[XLEN-1:0], stall_cnt. All other outputs are combinational from state and inputs.
- Qualification: ex_redirect_i and trap_i are ignored while mem_stall_req_i=1. Define req = trap_i | ex_redirect_i (qualified). Define tgt = trap_pc_i if trap_i, else ex_redirect_pc_i.
- No output pair may have hold=1 and clear=1 at the same time. redirect_o=1 forces pc_hold_o=0.
- RUN, decisions in priority order:
  1. mem_stall_req_i: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_clear. The fetch stage keeps its response stable while pc_hold_o=1.
  2. req with if_stall_req_i=0: redirect_o=1, redirect_pc_o=tgt, if_id_clear, id_ex_clear.
     - If trap_i, also ex_mem_clear and mem_wb_clear.
     - Stay RUN.
  3. req with if_stall_req_i=1: pending_pc<=tgt, next state PEND, pc_hold, same clears as step 2, redirect_o=0.
  4. id_load_use_i: pc_hold, if_id_hold, id_ex_clear.
  5. if_stall_req_i: pc_hold, if_id_clear.
  6. Otherwise all controls 0.
- PEND:
  - mem_stall_req_i: same holds/clear as RUN step 1, except that if_id_clear replaces if_id_hold and pc_hold=1. Fetch-completion exit still applies (see below).
  - Trap while pending: trap_i (qualified) overwrites pending_pc<=trap_pc_i and asserts if_id, id_ex, ex_mem and mem_wb clears.
  - Fetch still busy (if_stall_req_i=1): pc_hold=1, if_id_clear=1. id_load_use_i and ex_redirect_i are ignored.
  - Fetch complete (if_stall_req_i=0): redirect_o=1, redirect_pc_o=pending_pc, if_id_clear=1 to discard the wrong-path instruction, next state RUN.
  - Trap in the exit cycle: redirect_pc_o=trap_pc_i and the trap clears apply.
- stall_cnt: +1 on every cycle with pc_hold_o=1; saturates at 2^CNT_W-1; no wrap.
- redirect_pc_o=0 whenever redirect_o=0.

## Timing
- Reset (rst_n=0, async): state=RUN, pending_pc=0, stall_cnt=0. All combinational outputs are forced to 0 while rst_n=0, regardless of inputs.
- Hold/clear/redirect outputs have zero latency: same cycle as the causing input. Registers act on the next posedge.
- Redirect with fetch idle: PC loads the target at the next edge.
- Redirect with fetch busy: target is applied on the first cycle with if_stall_req_i=0, and the instruction returned in that cycle never enters ID.
- Reset asserted in PEND discards pending_pc; no redirect is issued after reset.

## Test plan
- Reset then idle: all outputs 0 and stall_cnt_o=0. Hold rst_n=0 with mem_stall_req_i=1 -> outputs still 0.
- Load-use 1 cycle -> pc_hold=1, if_id_hold=1, id_ex_clear=1 for that cycle only. stall_cnt_o=1 after the edge.
- ex_redirect_i with ex_redirect_pc_i=0x8000_0040 and fetch idle -> redirect_o=1, redirect_pc_o=0x8000_0040, if_id_clear=1, id_ex_clear=1 in the same cycle.
- ex_redirect_i (0x8000_0100) with if_stall_req_i high for 3 more cycles -> PEND entered; pc_hold=1 and if_id_clear=1 for 4 cycles; on the cycle if_stall_req_i falls, redirect_o=1 with 0x8000_0100; then RUN.
- In PEND, trap_i with trap_pc_i=0x8000_0000 -> all four clears asserted; exit redirect uses 0x8000_0000.
- mem_stall_req_i held together with ex_redirect_i -> redirect ignored; pc/if_id/id_ex/ex_mem hold and mem_wb_clear asserted. Separately, force 2^CNT_W-1 stall cycles (CNT_W=4 build) -> stall_cnt_o saturates at 15.
